result_tx_serializer: RTL and testbench
=======================================

Name: result_tx_serializer

Overview:
- Return path of the UART calculator: captures a signed datapath result and sends it to the TX UART interface as bytes, MSB first.
- Byte order mirrors the receive-side operand assembly, which loads MSB then LSB.
- Sits between datapath/controller and TX UART; reports completion to the controller.

Parameters:
- NUM_BYTES, 2, number of bytes per result; result width RES_W = 8*NUM_BYTES; legal range 1..4.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- Result_valid_in  input  1  from controller; one-cycle pulse, Result_in valid this cycle.
- Result_in  input  RES_W  from datapath; signed result, two's complement.
- Tx_busy_in  input  1  from TX UART; high while a byte is being shifted out.
- Tx_start_out  output  1  to TX UART; one-cycle request to send Tx_Byte_out.
- Tx_Byte_out  output  8  to TX UART; byte to transmit.
- Busy_out  output  1  to controller; high from capture until Done_out.
- Done_out  output  1  to controller; one-cycle pulse after the last byte finishes.

Behaviour:
- Reset (async, RST=0):
  - State IDLE; shift register, byte counter, Tx_Byte_out = 0.
  - Tx_start_out, Busy_out, Done_out = 0.
  - Applies at any point, including mid-byte; no partial frame resumes after reset release.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, ARM, ACK, DRAIN, DONE.
- IDLE:
  - On a rising edge with Result_valid_in=1: latch Result_in into a RES_W shift register, load byte counter = NUM_BYTES-1, set Busy_out=1, go to ARM.
  - Result_valid_in is ignored in every other state; no queueing and no error flag.
- ARM:
  - Waits while Tx_busy_in=1, so an earlier UART activity is never overlapped.
  - When Tx_busy_in=0: drive Tx_byte_out = shreg[RES_W-1 -: 8] and pulse Tx_start_out=1 for exactly one cycle, then go to ACK.
  - Tx_Byte_out updates in the same cycle as Tx_start_out and holds until the next ARM load.
- ACK:
  - Waits for Tx_busy_in=1 (TX acceptance), then goes to DRAIN. No timeout.
- DRAIN:
  - Waits for Tx_busy_in=0.
  - If counter != 0: shift register left by 8, decrement counter, go to ARM.
  - If counter == 0: go to DONE.
- DONE:
  - Done_out=1 and Busy_out=0 for this single cycle, then go to IDLE.
  - Result_valid_in is accepted from the next cycle, in IDLE.
- Latency (TX raises busy the cycle after start; busy lasts B cycles):
  - Tx_start_out for byte 0 appears 2 cycles after the Result_valid_in edge.
  - Each following byte starts 2 cycles after the previous busy falls.
- Arithmetic: none. Bytes are raw two's-complement slices, MSB first; sign is not re-extended.
- NUM_BYTES=1: one pass through ARM/ACK/DRAIN, then DONE.
- A Tx_busy_in glitch high in ARM delays the start pulse only. A Tx_start_out pulse is never repeated for the same byte.

Test Plan:
- NUM_BYTES=2, Result_in=16'h1234 pulse, TX model with busy for 10 cycles -> Tx_start_out pulses exactly twice with bytes 8'h12 then 8'h34; Done_out pulses once; Busy_out high throughout, low on the Done cycle.
- Result_in=-16'sd2 -> bytes 8'hFF then 8'hFE; then Result_in=16'sh8000 -> 8'h80, 8'h00.
- Second Result_valid_in pulse with 16'hABCD mid-transfer of 16'h1234 -> only 8'h12, 8'h34 sent, one Done_out; a fresh pulse after Done_out sends 8'hAB, 8'hCD.
- Tx_busy_in held high for 20 cycles when Result_valid_in arrives -> no Tx_start_out until busy falls; start appears 1 cycle after the fall.
- RST asserted low during DRAIN of byte 0 -> all outputs 0 immediately, asynchronously; after release no start pulse without a new Result_valid_in.
- NUM_BYTES=4, Result_in=32'hDEADBEEF -> bytes DE, AD, BE, EF in order; NUM_BYTES=1, 8'h7F -> single byte, Done_out follows.

Source files
------------

// File: rtl/result_tx_serializer_if.sv
// Handshake bundle between controller/datapath, the result serializer and the TX UART.
// The slave modport is the serializer's view; master is the driving side.
interface result_tx_if #(
    parameter int NUM_BYTES = 2
);
    localparam int RES_W = 8 * NUM_BYTES;

    logic                    Result_valid_in;
    logic signed [RES_W-1:0] Result_in;
    logic                    Tx_busy_in;
    logic                    Tx_start_out;
    logic [7:0]              Tx_Byte_out;
    logic                    Busy_out;
    logic                    Done_out;

    modport slave (
        input  Result_valid_in,
        input  Result_in,
        input  Tx_busy_in,
        output Tx_start_out,
        output Tx_Byte_out,
        output Busy_out,
        output Done_out
    );

    modport master (
        output Result_valid_in,
        output Result_in,
        output Tx_busy_in,
        input  Tx_start_out,
        input  Tx_Byte_out,
        input  Busy_out,
        input  Done_out
    );
endinterface

// File: rtl/result_tx_serializer.sv
// Captures a signed result and feeds it to the TX UART one byte at a time, MSB first,
// waiting for the UART to accept and finish each byte before arming the next.
module result_tx_serializer #(
    parameter int NUM_BYTES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    result_tx_if.slave  bus
);
    localparam int RES_W = 8 * NUM_BYTES;

    typedef enum logic [2:0] {IDLE, ARM, ACK, DRAIN, DONE} state_t;

    state_t                  state_q;
    logic signed [RES_W-1:0] shreg_q;
    logic [1:0]              cnt_q;
    logic                    start_q;
    logic [7:0]              byte_q;
    logic                    busy_q;
    logic                    done_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Start and done are single-cycle strobes unless a state re-asserts them.
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Result_valid_in) begin
                        shreg_q <= bus.Result_in;
                        cnt_q   <= 2'(NUM_BYTES - 1);
                        busy_q  <= 1'b1;
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (!bus.Tx_busy_in) begin
                        byte_q  <= shreg_q[RES_W-1 -: 8];
                        start_q <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (bus.Tx_busy_in) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.Tx_busy_in) begin
                        if (cnt_q != 2'd0) begin
                            shreg_q <= shreg_q << 8;
                            cnt_q   <= cnt_q - 2'd1;
                            state_q <= ARM;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Tx_start_out = start_q;
    assign bus.Tx_Byte_out  = byte_q;
    assign bus.Busy_out     = busy_q;
    assign bus.Done_out     = done_q;
endmodule

// File: tb/tb_result_tx_serializer.sv
// Directed bench for result_tx_serializer at NUM_BYTES = 2, 4 and 1 with a shared TX UART model.
module tb_result_tx_serializer;
    localparam int B = 10;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    result_tx_if #(.NUM_BYTES(2)) if2 ();
    result_tx_if #(.NUM_BYTES(4)) if4 ();
    result_tx_if #(.NUM_BYTES(1)) if1 ();

    result_tx_serializer #(.NUM_BYTES(2)) dut2 (.CLK(CLK), .RST(RST), .bus(if2.slave));
    result_tx_serializer #(.NUM_BYTES(4)) dut4 (.CLK(CLK), .RST(RST), .bus(if4.slave));
    result_tx_serializer #(.NUM_BYTES(1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1.slave));

    logic tx_busy_model = 1'b0;
    logic tx_force      = 1'b0;
    int   tx_cnt        = 0;

    assign if2.Tx_busy_in = tx_busy_model | tx_force;
    assign if4.Tx_busy_in = tx_busy_model | tx_force;
    assign if1.Tx_busy_in = tx_busy_model | tx_force;

    int checks = 0;
    int errors = 0;
    logic [7:0] sent_q [$];
    int done2 = 0;
    int done4 = 0;
    int done1 = 0;

    // UART model: busy rises the cycle after a start pulse and lasts B cycles.
    always @(negedge CLK) begin
        if (if2.Tx_start_out || if4.Tx_start_out || if1.Tx_start_out) begin
            tx_busy_model <= 1'b1;
            tx_cnt        <= B;
        end else if (tx_cnt > 0) begin
            if (tx_cnt == 1) tx_busy_model <= 1'b0;
            tx_cnt <= tx_cnt - 1;
        end
    end

    always @(negedge CLK) begin
        if (if2.Tx_start_out) sent_q.push_back(if2.Tx_Byte_out);
        if (if4.Tx_start_out) sent_q.push_back(if4.Tx_Byte_out);
        if (if1.Tx_start_out) sent_q.push_back(if1.Tx_Byte_out);
        if (if2.Done_out) done2 <= done2 + 1;
        if (if4.Done_out) done4 <= done4 + 1;
        if (if1.Done_out) done1 <= done1 + 1;
    end

    task automatic pulse2(input logic [15:0] v);
        @(negedge CLK);
        if2.Result_in = v;
        if2.Result_valid_in = 1'b1;
        @(negedge CLK);
        if2.Result_valid_in = 1'b0;
    endtask

    task automatic pulse4(input logic [31:0] v);
        @(negedge CLK);
        if4.Result_in = v;
        if4.Result_valid_in = 1'b1;
        @(negedge CLK);
        if4.Result_valid_in = 1'b0;
    endtask

    task automatic pulse1(input logic [7:0] v);
        @(negedge CLK);
        if1.Result_in = v;
        if1.Result_valid_in = 1'b1;
        @(negedge CLK);
        if1.Result_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (!tx_busy_model && !if2.Busy_out && !if4.Busy_out && !if1.Busy_out) break;
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_done2(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge CLK);
            if (if2.Done_out) seen = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({if2.Tx_start_out, if2.Busy_out, if2.Done_out, if2.Tx_Byte_out} !== 11'h0 ||
            {if4.Tx_start_out, if4.Busy_out, if4.Done_out, if1.Tx_start_out, if1.Busy_out} !== 5'h0) begin
            errors++;
            $display("FAIL reset_state: got start=%b busy=%b done=%b byte=%h, expected all 0",
                     if2.Tx_start_out, if2.Busy_out, if2.Done_out, if2.Tx_Byte_out);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_basic();
        int base, d, viol;
        bit seen;
        base = sent_q.size();
        d = done2;
        pulse2(16'h1234);
        checks++;
        if (if2.Busy_out !== 1'b1 || if2.Tx_start_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_capture: got busy=%b start=%b, expected busy=1 start=0",
                     if2.Busy_out, if2.Tx_start_out);
        end
        @(negedge CLK);
        checks++;
        if (if2.Tx_start_out !== 1'b1 || if2.Tx_Byte_out !== 8'h12) begin
            errors++;
            $display("FAIL basic_first_start: got start=%b byte=%h, expected start=1 byte=12",
                     if2.Tx_start_out, if2.Tx_Byte_out);
        end
        viol = 0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge CLK);
            if (if2.Done_out) begin
                seen = 1'b1;
                if (if2.Busy_out !== 1'b0) viol++;
            end else if (if2.Busy_out !== 1'b1) begin
                viol++;
            end
        end
        #1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL basic_done_timeout: got no Done_out, expected one within budget");
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL basic_busy_profile: got %0d bad Busy_out cycles, expected 0", viol);
        end
        checks++;
        if (sent_q.size() != base + 2) begin
            errors++;
            $display("FAIL basic_byte_count: got %0d bytes, expected 2", sent_q.size() - base);
        end else if (sent_q[base] !== 8'h12 || sent_q[base+1] !== 8'h34) begin
            errors++;
            $display("FAIL basic_bytes: got %h %h, expected 12 34", sent_q[base], sent_q[base+1]);
        end
        @(negedge CLK);
        checks++;
        if (done2 != d + 1 || if2.Done_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %0d pulses done_now=%b, expected 1 pulse done_now=0",
                     done2 - d, if2.Done_out);
        end
        wait_idle();
    endtask

    task automatic test_signed();
        logic signed [15:0] vals [2];
        logic [7:0] exp_hi [2];
        logic [7:0] exp_lo [2];
        int base;
        bit seen;
        vals[0] = -16'sd2;    exp_hi[0] = 8'hFF; exp_lo[0] = 8'hFE;
        vals[1] = 16'sh8000;  exp_hi[1] = 8'h80; exp_lo[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            base = sent_q.size();
            pulse2(vals[k]);
            wait_done2(seen);
            checks++;
            if (!seen || sent_q.size() != base + 2) begin
                errors++;
                $display("FAIL signed_%0d_count: got done=%b bytes=%0d, expected done=1 bytes=2",
                         k, seen, sent_q.size() - base);
            end else if (sent_q[base] !== exp_hi[k] || sent_q[base+1] !== exp_lo[k]) begin
                errors++;
                $display("FAIL signed_%0d_bytes: got %h %h, expected %h %h",
                         k, sent_q[base], sent_q[base+1], exp_hi[k], exp_lo[k]);
            end
            wait_idle();
        end
    endtask

    task automatic test_ignore();
        int base, d;
        bit seen;
        base = sent_q.size();
        d = done2;
        pulse2(16'h1234);
        repeat (5) @(negedge CLK);
        pulse2(16'hABCD);
        wait_done2(seen);
        repeat (20) @(negedge CLK);
        #1;
        checks++;
        if (sent_q.size() != base + 2 || done2 != d + 1) begin
            errors++;
            $display("FAIL ignore_count: got bytes=%0d done=%0d, expected bytes=2 done=1",
                     sent_q.size() - base, done2 - d);
        end else if (sent_q[base] !== 8'h12 || sent_q[base+1] !== 8'h34) begin
            errors++;
            $display("FAIL ignore_bytes: got %h %h, expected 12 34", sent_q[base], sent_q[base+1]);
        end
        wait_idle();
        base = sent_q.size();
        pulse2(16'hABCD);
        wait_done2(seen);
        checks++;
        if (!seen || sent_q.size() != base + 2) begin
            errors++;
            $display("FAIL ignore_fresh_count: got done=%b bytes=%0d, expected done=1 bytes=2",
                     seen, sent_q.size() - base);
        end else if (sent_q[base] !== 8'hAB || sent_q[base+1] !== 8'hCD) begin
            errors++;
            $display("FAIL ignore_fresh_bytes: got %h %h, expected ab cd", sent_q[base], sent_q[base+1]);
        end
        wait_idle();
    endtask

    task automatic test_busy_hold();
        int starts, base;
        bit seen;
        @(negedge CLK);
        tx_force = 1'b1;
        base = sent_q.size();
        pulse2(16'h5A3C);
        starts = 0;
        repeat (20) begin
            @(negedge CLK);
            if (if2.Tx_start_out) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL hold_no_start: got %0d starts while busy, expected 0", starts);
        end
        tx_force = 1'b0;
        @(negedge CLK);
        checks++;
        if (if2.Tx_start_out !== 1'b1 || if2.Tx_Byte_out !== 8'h5A) begin
            errors++;
            $display("FAIL hold_start_after_fall: got start=%b byte=%h, expected start=1 byte=5a",
                     if2.Tx_start_out, if2.Tx_Byte_out);
        end
        wait_done2(seen);
        checks++;
        if (!seen || sent_q.size() != base + 2) begin
            errors++;
            $display("FAIL hold_count: got done=%b bytes=%0d, expected done=1 bytes=2",
                     seen, sent_q.size() - base);
        end else if (sent_q[base] !== 8'h5A || sent_q[base+1] !== 8'h3C) begin
            errors++;
            $display("FAIL hold_bytes: got %h %h, expected 5a 3c", sent_q[base], sent_q[base+1]);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int starts, base;
        bit seen;
        pulse2(16'h1234);
        for (int i = 0; i < 50 && !tx_busy_model; i++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({if2.Tx_start_out, if2.Busy_out, if2.Done_out, if2.Tx_Byte_out} !== 11'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got start=%b busy=%b done=%b byte=%h, expected all 0",
                     if2.Tx_start_out, if2.Busy_out, if2.Done_out, if2.Tx_Byte_out);
        end
        @(negedge CLK);
        RST = 1'b1;
        starts = 0;
        repeat (40) begin
            @(negedge CLK);
            if (if2.Tx_start_out || if2.Busy_out) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL midreset_no_resume: got %0d active cycles, expected 0", starts);
        end
        wait_idle();
        base = sent_q.size();
        pulse2(16'h00FF);
        wait_done2(seen);
        checks++;
        if (!seen || sent_q.size() != base + 2) begin
            errors++;
            $display("FAIL midreset_recover_count: got done=%b bytes=%0d, expected done=1 bytes=2",
                     seen, sent_q.size() - base);
        end else if (sent_q[base] !== 8'h00 || sent_q[base+1] !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_recover_bytes: got %h %h, expected 00 ff", sent_q[base], sent_q[base+1]);
        end
        wait_idle();
    endtask

    task automatic test_nb4();
        int base, d;
        bit seen;
        base = sent_q.size();
        d = done4;
        pulse4(32'hDEADBEEF);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge CLK);
            if (if4.Done_out) seen = 1'b1;
        end
        @(negedge CLK);
        #1;
        checks++;
        if (!seen || sent_q.size() != base + 4 || done4 != d + 1) begin
            errors++;
            $display("FAIL nb4_count: got done=%0d bytes=%0d, expected done=1 bytes=4",
                     done4 - d, sent_q.size() - base);
        end else if ({sent_q[base], sent_q[base+1], sent_q[base+2], sent_q[base+3]} !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL nb4_bytes: got %h %h %h %h, expected de ad be ef",
                     sent_q[base], sent_q[base+1], sent_q[base+2], sent_q[base+3]);
        end
        wait_idle();
    endtask

    task automatic test_nb1();
        int base, d;
        bit seen;
        base = sent_q.size();
        d = done1;
        pulse1(8'h7F);
        @(negedge CLK);
        checks++;
        if (if1.Tx_start_out !== 1'b1 || if1.Tx_Byte_out !== 8'h7F) begin
            errors++;
            $display("FAIL nb1_start: got start=%b byte=%h, expected start=1 byte=7f",
                     if1.Tx_start_out, if1.Tx_Byte_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK);
            if (if1.Done_out) seen = 1'b1;
        end
        @(negedge CLK);
        #1;
        checks++;
        if (!seen || sent_q.size() != base + 1 || done1 != d + 1) begin
            errors++;
            $display("FAIL nb1_count: got done=%0d bytes=%0d, expected done=1 bytes=1",
                     done1 - d, sent_q.size() - base);
        end else if (sent_q[base] !== 8'h7F) begin
            errors++;
            $display("FAIL nb1_byte: got %h, expected 7f", sent_q[base]);
        end
        wait_idle();
    endtask

    initial begin
        if2.Result_valid_in = 1'b0;
        if2.Result_in       = '0;
        if4.Result_valid_in = 1'b0;
        if4.Result_in       = '0;
        if1.Result_valid_in = 1'b0;
        if1.Result_in       = '0;
        test_reset();
        test_basic();
        test_signed();
        test_ignore();
        test_busy_hold();
        test_reset_mid();
        test_nb4();
        test_nb1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
